nibble_sub_driver: RTL and testbench
====================================

// Module: nibble_sub_driver
// PURPOSE
//  Initiator side of the packed-nibble subtract interface. Generates operand pairs and drives them
//  packed {b,a} on an 8-bit bus. Waits the responder's fixed register latency, captures the 5-bit
//  difference, and checks it against an internal model. Sits on-chip as a BIST source/checker in
//  front of the subtractor core; reports pass/fail and error counts to the host.
// PARAMETERS
//  NUM_VECTORS  16     operand pairs per run (1..255)
//  LATENCY      1      cycles from op_out change to valid res_in (1..7)
//  LFSR_SEED    8'hA5  initial operand LFSR state; 8'h00 is replaced by 8'h01
// PORTS
//  clk        in   1  clock
//  rst        in   1  asynchronous reset, active high
//  start      in   1  one-cycle pulse; begins a run when idle
//  op_out     out  8  packed operands: [3:0]=a (minuend), [7:4]=b (subtrahend)
//  res_in     in   5  difference returned by responder
//  busy       out  1  high from the cycle after accepted start until done
//  done       out  1  one-cycle pulse when the run completes
//  pass       out  1  sticky: 1 if the last run had zero mismatches; cleared on start
//  err_count  out  8  mismatches in current/last run; saturates at 8'hFF
//  fail_op    out  8  op_out of the first mismatching vector (0 if none)
//  fail_res   out  5  res_in captured at the first mismatch (0 if none)
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; op_out=0, busy=0, done=0, pass=0, err_count=0,
//    fail_op=0, fail_res=0, LFSR=LFSR_SEED (0 -> 1), vector counter=0.
//  - Expected value: exp = ({1'b0,a} - {1'b0,b}) mod 32. Example: a=3,b=5 -> 5'h1E; a=F,b=0 -> 5'h0F.
//  - LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, shifts once per vector after CHECK; op_out=LFSR state.
//  - FSM:
//    IDLE : start=1 -> clear err_count/pass/fail_*, load op_out=LFSR, wcnt=LATENCY, go WAIT.
//    WAIT : wcnt decrements each cycle; op_out held stable; at wcnt==1 go CHECK.
//    CHECK: compare res_in with exp(op_out). On mismatch: err_count+1 (sat); first mismatch also
//           loads fail_op/fail_res. If vector count==NUM_VECTORS-1 go DONE, else advance the LFSR,
//           drive the new op_out, increment the vector counter, reload wcnt, go WAIT.
//    DONE : done=1 for exactly one cycle; pass=(err_count==0 incl. this run); go IDLE.
//  - Timing: res_in is sampled in CHECK, exactly LATENCY+1 edges after op_out is updated. With
//    LATENCY=1, one vector takes 2 cycles; a run takes 2*NUM_VECTORS+1 cycles from start to done.
//  - start while busy or in DONE: ignored, no effect on counters.
//  - LFSR is not reseeded between runs; consecutive runs continue the sequence.
//  - op_out holds its last value in IDLE and DONE (no glitch back to 0).
//  - Reset mid-run: immediate return to IDLE with reset values; no done pulse issued.
//  - res_in is ignored outside CHECK.
// STRUCTURE
//  - Package nibble_sub_pkg: state enum {IDLE,WAIT,CHECK,DONE}, NIBBLE_W=4, RES_W=5,
//    LFSR taps constant, function exp_diff(input [7:0] op) returning the 5-bit model.
//  - Sub-module operand_lfsr (8-bit, seed/advance/state ports), shared with future BIST sources.
//  - Top: FSM, wait counter, vector counter, checker/saturating error counter, fail capture.
// TESTING
//  1. Good responder, LATENCY=1, seed 8'h53, NUM_VECTORS=1: op_out=8'h53 -> res 5'h1E; done after
//     3 cycles; pass=1; err_count=0.
//  2. Good responder, NUM_VECTORS=16, seed 8'hA5: 16 distinct op_out values matching the bench LFSR
//     model; done exactly 33 cycles after start; pass=1.
//  3. Faulty responder (res bit4 stuck 0) -> err_count equals count of vectors with b>a;
//     fail_op/fail_res hold the first such vector; pass=0.
//  4. LATENCY=3 with a matching 3-stage responder -> pass=1; with a 1-stage responder -> mismatches
//     reported, not silently passed.
//  5. Assert rst mid-run (vector 5) -> all outputs zero the same cycle, no done; new start gives a
//     clean run from LFSR_SEED.
//  6. start pulses during busy and during DONE -> ignored; LFSR_SEED=0 -> first op_out=8'h01.

Source files
------------

// File: rtl/nibble_sub_pkg.sv
// Shared types, widths and reference functions for the packed-nibble subtract BIST.
package nibble_sub_pkg;

    localparam int NIBBLE_W = 4;
    localparam int RES_W    = 5;
    localparam int OP_W     = 2 * NIBBLE_W;

    // FSM encodings kept as plain constants so older tools and netlists agree on values.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3.
    localparam logic [OP_W-1:0] LFSR_TAPS = 8'hB8;

    // Reference difference: zero-extended a minus zero-extended b, wrapped to 5 bits.
    function automatic logic [RES_W-1:0] exp_diff(input logic [OP_W-1:0] op);
        exp_diff = {1'b0, op[NIBBLE_W-1:0]} - {1'b0, op[OP_W-1:NIBBLE_W]};
    endfunction

    // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0.
    function automatic logic [OP_W-1:0] lfsr_step(input logic [OP_W-1:0] s);
        lfsr_step = {s[OP_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // The all-zero state locks the LFSR, so it is replaced by 1.
    function automatic logic [OP_W-1:0] safe_seed(input logic [OP_W-1:0] s);
        safe_seed = (s == '0) ? 8'h01 : s;
    endfunction

endpackage

// File: rtl/nibble_sub_driver_lfsr.sv
// Operand generator: 8-bit Fibonacci LFSR with optional runtime reseed.
// The next state is exported so a consumer can load it in the same cycle the register advances.
module operand_lfsr
    import nibble_sub_pkg::*;
#(
    parameter logic [OP_W-1:0] SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [OP_W-1:0] seed,
    input  logic            advance,
    output logic [OP_W-1:0] state,
    output logic [OP_W-1:0] next_state
);

    logic [OP_W-1:0] lfsr_q;
    logic [OP_W-1:0] lfsr_d;
    logic [OP_W-1:0] lfsr_step_val;

    assign lfsr_step_val = lfsr_step(lfsr_q);

    // Select between holding, reseeding and stepping the register.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = safe_seed(seed);
        end else if (advance) begin
            lfsr_d = lfsr_step_val;
        end
    end

    // State register; reset always lands on a non-zero seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= safe_seed(SEED);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state      = lfsr_q;
    assign next_state = lfsr_step_val;

endmodule

// File: rtl/nibble_sub_driver.sv
// BIST initiator for the packed-nibble subtractor: drives {b,a} operand pairs from an LFSR,
// waits the responder latency, checks the 5-bit difference and reports pass/error status.
module nibble_sub_driver
    import nibble_sub_pkg::*;
#(
    parameter int              NUM_VECTORS = 16,
    parameter int              LATENCY     = 1,
    parameter logic [OP_W-1:0] LFSR_SEED   = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [OP_W-1:0]  op_out,
    input  logic [RES_W-1:0] res_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [OP_W-1:0]  fail_op,
    output logic [RES_W-1:0] fail_res
);

    localparam logic [7:0] LAST_VEC  = 8'(NUM_VECTORS - 1);
    localparam logic [2:0] WAIT_LOAD = 3'(LATENCY);

    state_t           state_q,  state_d;
    logic [2:0]       wcnt_q,   wcnt_d;
    logic [7:0]       vcnt_q,   vcnt_d;
    logic [OP_W-1:0]  op_q,     op_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             pass_q,   pass_d;
    logic [7:0]       err_q,    err_d;
    logic [OP_W-1:0]  fop_q,    fop_d;
    logic [RES_W-1:0] fres_q,   fres_d;

    logic             lfsr_advance;
    logic [OP_W-1:0]  lfsr_state;
    logic [OP_W-1:0]  lfsr_next;
    logic             mismatch;

    operand_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .seed      (LFSR_SEED),
        .advance   (lfsr_advance),
        .state     (lfsr_state),
        .next_state(lfsr_next)
    );

    assign mismatch = (res_in != exp_diff(op_q));

    // Run sequencing, operand drive, result checking and first-failure capture.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        vcnt_d       = vcnt_q;
        op_d         = op_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_d        = err_q;
        fop_d        = fop_q;
        fres_d       = fres_q;
        lfsr_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 8'h00;
                    pass_d  = 1'b0;
                    fop_d   = '0;
                    fres_d  = '0;
                    op_d    = lfsr_state;
                    wcnt_d  = WAIT_LOAD;
                    vcnt_d  = 8'h00;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (wcnt_q <= 3'd1) begin
                    state_d = ST_CHECK;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (err_q == 8'h00) begin
                        fop_d  = op_q;
                        fres_d = res_in;
                    end
                end
                // The sequence advances after every vector so the next run continues it.
                lfsr_advance = 1'b1;
                if (vcnt_q == LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    op_d    = lfsr_next;
                    vcnt_d  = vcnt_q + 8'd1;
                    wcnt_d  = WAIT_LOAD;
                    state_d = ST_WAIT;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == 8'h00);
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All control and status registers; reset abandons any run without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 3'd0;
            vcnt_q  <= 8'h00;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 8'h00;
            fop_q   <= '0;
            fres_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            vcnt_q  <= vcnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fop_q   <= fop_d;
            fres_q  <= fres_d;
        end
    end

    assign op_out    = op_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_op   = fop_q;
    assign fail_res  = fres_q;

endmodule

// File: tb/tb_nibble_sub_driver.sv
// Self-checking bench for nibble_sub_driver: four configurations, bench-side responders,
// and a timeline model of the main instance compared on every falling edge.
module tb_nibble_sub_driver;

    localparam logic [7:0] SEED_B = 8'hA5;
    localparam int         NV_B   = 16;

    logic clk;
    logic rst;
    logic start_a, start_b, start_c, start_d;
    logic [7:0] op_a, op_b, op_c, op_d;
    logic [4:0] res_a, res_b, res_c, res_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic done_a, done_b, done_c, done_d;
    logic pass_a, pass_b, pass_c, pass_d;
    logic [7:0] err_a, err_b, err_c, err_d;
    logic [7:0] fop_a, fop_b, fop_c, fop_d;
    logic [4:0] fres_a, fres_b, fres_c, fres_d;

    int errors = 0;
    int checks = 0;

    // 0 = good 1-stage responder, 1 = bit4 stuck at 0, 2 = 3-stage pipeline (too slow)
    int mode_b = 0;
    logic [4:0] rb1, rb2, rb3;
    logic [4:0] rc1, rc2, rc3;
    bit cmp_en = 0;

    // Timeline model of instance B
    logic [7:0] m_lfsr, m_op, m_fop;
    logic [4:0] m_fres;
    logic m_busy, m_done, m_pass, m_active;
    int m_err, m_e;
    logic [7:0] run_ops[$];

    int cyc, cnt, distinct;
    logic [7:0] first_op;
    bit dup;

    initial clk = 0;
    always #5 clk = ~clk;

    nibble_sub_driver #(.NUM_VECTORS(1), .LATENCY(1), .LFSR_SEED(8'h53)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .op_out(op_a), .res_in(res_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .err_count(err_a), .fail_op(fop_a), .fail_res(fres_a));
    nibble_sub_driver #(.NUM_VECTORS(NV_B), .LATENCY(1), .LFSR_SEED(SEED_B)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .op_out(op_b), .res_in(res_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .err_count(err_b), .fail_op(fop_b), .fail_res(fres_b));
    nibble_sub_driver #(.NUM_VECTORS(8), .LATENCY(3), .LFSR_SEED(8'hA5)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .op_out(op_c), .res_in(res_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .err_count(err_c), .fail_op(fop_c), .fail_res(fres_c));
    nibble_sub_driver #(.NUM_VECTORS(2), .LATENCY(1), .LFSR_SEED(8'h00)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .op_out(op_d), .res_in(res_d), .busy(busy_d),
        .done(done_d), .pass(pass_d), .err_count(err_d), .fail_op(fop_d), .fail_res(fres_d));

    // a - b as integers, wrapped into 0..31
    function automatic logic [4:0] tb_exp(input logic [7:0] op);
        int d;
        d = int'(op[3:0]) - int'(op[7:4]);
        if (d < 0) d = d + 32;
        return 5'(d);
    endfunction

    // x^8+x^6+x^5+x^4+1, shifting towards the MSB
    function automatic logic [7:0] tb_lfsr(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    // Responders: registered subtractors of various depths and faults
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_a <= '0; res_d <= '0;
            rb1 <= '0; rb2 <= '0; rb3 <= '0;
            rc1 <= '0; rc2 <= '0; rc3 <= '0;
        end else begin
            res_a <= tb_exp(op_a);
            res_d <= tb_exp(op_d);
            rb1 <= tb_exp(op_b); rb2 <= rb1; rb3 <= rb2;
            rc1 <= tb_exp(op_c); rc2 <= rc1; rc3 <= rc2;
        end
    end

    assign res_b = (mode_b == 2) ? rb3 : (mode_b == 1) ? (rb1 & 5'h0F) : rb1;
    assign res_c = rc3;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int which);
        @(negedge clk);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            2: start_c = 1'b1;
            default: start_d = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    endtask

    function automatic logic doneOf(input int which);
        case (which)
            0: return done_a;
            1: return done_b;
            2: return done_c;
            default: return done_d;
        endcase
    endfunction

    // Counts falling edges after the start edge until done is seen, bounded
    task automatic waitDone(input int which, output int cycles);
        cycles = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            cycles++;
            if (doneOf(which)) return;
        end
        checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Model: vector i driven at start edge + 2i, checked at + 2i + 2, done at + 2N + 1
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_lfsr = SEED_B; m_op = 0; m_busy = 0; m_done = 0; m_pass = 0;
                m_err = 0; m_fop = 0; m_fres = 0; m_active = 0; m_e = 0;
            end else begin
                m_done = 1'b0;
                if (!m_active) begin
                    if (start_b) begin
                        m_active = 1; m_e = 0; m_busy = 1; m_err = 0; m_pass = 0;
                        m_fop = 0; m_fres = 0; m_op = m_lfsr;
                        run_ops.delete();
                        run_ops.push_back(m_op);
                    end
                end else begin
                    m_e++;
                    if (m_e == 2 * NV_B + 1) begin
                        m_active = 0; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                    end else if (m_e % 2 == 0) begin
                        if (res_b !== tb_exp(m_op)) begin
                            if (m_err == 0) begin m_fop = m_op; m_fres = res_b; end
                            if (m_err < 255) m_err++;
                        end
                        m_lfsr = tb_lfsr(m_lfsr);
                        if (m_e / 2 < NV_B) begin
                            m_op = m_lfsr;
                            run_ops.push_back(m_op);
                        end
                    end
                end
            end
        end
    end

    // Compare instance B against the model every falling edge outside reset
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !rst) begin
                checkOutput("b_op_out", op_b, m_op);
                checkOutput("b_busy", busy_b, m_busy);
                checkOutput("b_done", done_b, m_done);
                checkOutput("b_pass", pass_b, m_pass);
                checkOutput("b_err_count", err_b, m_err);
                checkOutput("b_fail_op", fop_b, m_fop);
                checkOutput("b_fail_res", fres_b, m_fres);
            end
        end
    end

    initial begin
        rst = 1; start_a = 0; start_b = 0; start_c = 0; start_d = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_op", op_b, 0);
        checkOutput("rst_busy", busy_b, 0);
        checkOutput("rst_done", done_b, 0);
        checkOutput("rst_pass", pass_b, 0);
        checkOutput("rst_err", err_b, 0);
        checkOutput("rst_fop", fop_b, 0);
        checkOutput("rst_fres", fres_b, 0);
        rst = 0;
        cmp_en = 1;

        // Pin the model with hand-worked values
        checkOutput("model_exp_53", tb_exp(8'h53), 5'h1E);
        checkOutput("model_exp_0F", tb_exp(8'h0F), 5'h0F);
        checkOutput("model_lfsr_1", tb_lfsr(8'hA5), 8'h4A);
        checkOutput("model_lfsr_2", tb_lfsr(8'h4A), 8'h95);
        checkOutput("model_lfsr_3", tb_lfsr(8'h95), 8'h2A);
        checkOutput("model_lfsr_4", tb_lfsr(8'h2A), 8'h54);

        $display("[TB] single vector, seed 53");
        applyStimulus(0);
        checkOutput("a_op_first", op_a, 8'h53);
        waitDone(0, cyc);
        checkOutput("a_done_cycles", cyc, 3);
        checkOutput("a_pass", pass_a, 1);
        checkOutput("a_err", err_a, 0);
        checkOutput("a_res", res_a, 5'h1E);

        $display("[TB] sixteen vectors, good responder");
        applyStimulus(1);
        checkOutput("b_op_first", op_b, 8'hA5);
        waitDone(1, cyc);
        checkOutput("b_done_cycles", cyc, 33);
        checkOutput("b_pass_good", pass_b, 1);
        distinct = 0;
        for (int i = 0; i < run_ops.size(); i++) begin
            dup = 0;
            for (int j = 0; j < i; j++) if (run_ops[j] == run_ops[i]) dup = 1;
            if (!dup) distinct++;
        end
        checkOutput("b_distinct_ops", distinct, 16);

        $display("[TB] faulty responder, bit4 stuck low");
        mode_b = 1;
        applyStimulus(1);
        waitDone(1, cyc);
        cnt = 0; first_op = 8'h00;
        foreach (run_ops[i]) begin
            if (run_ops[i][7:4] > run_ops[i][3:0]) begin
                if (cnt == 0) first_op = run_ops[i];
                cnt++;
            end
        end
        checkOutput("fault_err_count", err_b, cnt);
        checkOutput("fault_fail_op", fop_b, first_op);
        checkOutput("fault_fail_res", fres_b, (cnt > 0) ? (tb_exp(first_op) & 5'h0F) : 5'h00);
        checkOutput("fault_pass", pass_b, (cnt == 0) ? 1 : 0);
        mode_b = 0;

        $display("[TB] latency 3 with matching responder");
        applyStimulus(2);
        waitDone(2, cyc);
        checkOutput("c_done_cycles", cyc, 33);
        checkOutput("c_pass", pass_c, 1);
        checkOutput("c_err", err_c, 0);

        $display("[TB] latency 1 against 3-stage responder");
        mode_b = 2;
        applyStimulus(1);
        waitDone(1, cyc);
        checkOutput("slow_pass", pass_b, 0);
        checkOutput("slow_err_nonzero", (err_b != 0) ? 1 : 0, 1);
        mode_b = 0;

        $display("[TB] start during busy and during DONE");
        applyStimulus(1);
        repeat (5) @(negedge clk);
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        repeat (26) @(negedge clk);
        checkOutput("ign_busy_before", busy_b, 1);
        checkOutput("ign_done_before", done_b, 0);
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        checkOutput("ign_done_pulse", done_b, 1);
        checkOutput("ign_pass", pass_b, 1);
        repeat (3) @(negedge clk);
        checkOutput("ign_idle_busy", busy_b, 0);

        $display("[TB] reset mid-run at vector 5");
        applyStimulus(1);
        repeat (10) @(negedge clk);
        #2;
        rst = 1;
        #1;
        checkOutput("mid_op", op_b, 0);
        checkOutput("mid_busy", busy_b, 0);
        checkOutput("mid_done", done_b, 0);
        checkOutput("mid_pass", pass_b, 0);
        checkOutput("mid_err", err_b, 0);
        checkOutput("mid_fop", fop_b, 0);
        checkOutput("mid_fres", fres_b, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checkOutput("mid_no_done", done_b, 0);
        applyStimulus(1);
        checkOutput("mid_restart_op", op_b, 8'hA5);
        waitDone(1, cyc);
        checkOutput("mid_restart_cycles", cyc, 33);
        checkOutput("mid_restart_pass", pass_b, 1);

        $display("[TB] zero seed");
        applyStimulus(3);
        checkOutput("d_op_first", op_d, 8'h01);
        waitDone(3, cyc);
        checkOutput("d_done_cycles", cyc, 5);
        checkOutput("d_pass", pass_d, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
